cpu_sequencer: RTL and testbench

- Multicycle control FSM for the 18-bit-instruction / 16-bit-datapath CPU.
- Owns the PC and the instruction register (IR). The IR feeds the instruction decoder.
- Sequences fetch, execute and memory phases.
- Gates register-file, flag and data-memory write strobes, and resolves JCOND jumps against the ALU flags.

---
 rtl/cpu_pkg.sv | 94 +++++++++
 rtl/branch_cond_eval.sv | 28 ++
 rtl/cpu_sequencer.sv | 114 +++++++++++
 tb/tb_cpu_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 18-bit-instruction CPU: sequencer states, opcode fields,
// branch condition codes, flag bit positions and the execute-class decode.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_LATCH = 2'b01,
        S_EXEC  = 2'b10,
        S_MEM   = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_LI,
        C_LOAD,
        C_STOR,
        C_JCOND,
        C_CMP,
        C_ARITH,
        C_OTHER
    } iclass_t;

    // Primary opcode, ir[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_SUBCI = 4'b1010;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_CMPUI = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Extended opcode, ir[7:4]
    localparam logic [3:0] EXT_LOAD_1 = 4'b0000;
    localparam logic [3:0] EXT_STOR_1 = 4'b0100;
    localparam logic [3:0] EXT_JCOND  = 4'b1100;
    localparam logic [3:0] EXT_SUBU   = 4'b0100;
    localparam logic [3:0] EXT_ADD    = 4'b0101;
    localparam logic [3:0] EXT_ADDU   = 4'b0110;
    localparam logic [3:0] EXT_ADDC   = 4'b0111;
    localparam logic [3:0] EXT_SUB    = 4'b1001;
    localparam logic [3:0] EXT_CMP    = 4'b1011;

    // Condition codes, ir[3:0] of JCOND
    localparam logic [3:0] COND_BEQ  = 4'b0000;
    localparam logic [3:0] COND_BNEQ = 4'b0001;
    localparam logic [3:0] COND_BGT  = 4'b0110;
    localparam logic [3:0] COND_BLT  = 4'b0111;
    localparam logic [3:0] COND_BLE  = 4'b1100;
    localparam logic [3:0] COND_BGE  = 4'b1101;
    localparam logic [3:0] COND_JUC  = 4'b1110;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

    // Earlier checks win: LI and NOP groups first, then the MEM group, then compares.
    function automatic iclass_t classify(input logic [17:0] instr);
        iclass_t    c;
        logic [3:0] op;
        logic [3:0] ext;
        op  = instr[15:12];
        ext = instr[7:4];
        c   = C_OTHER;
        if (instr[17:16] == 2'b11) begin
            c = C_LI;
        end else if (instr[17:16] != 2'b00) begin
            c = C_NOP;
        end else if (op == OP_MEM) begin
            case (ext)
                EXT_LOAD_1: c = C_LOAD;
                EXT_STOR_1: c = C_STOR;
                EXT_JCOND:  c = C_JCOND;
                default:    c = C_NOP;
            endcase
        end else if ((op == OP_RTYPE && ext == EXT_CMP) || op == OP_CMPI || op == OP_CMPUI) begin
            c = C_CMP;
        end else if ((op == OP_RTYPE && ext inside {EXT_ADD, EXT_ADDU, EXT_ADDC, EXT_SUBU, EXT_SUB})
                     || op inside {OP_ADDI, OP_ADDUI, OP_ADDCI, OP_SUBCI, OP_SUBI}) begin
            c = C_ARITH;
        end
        return c;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Resolves a JCOND condition code against the {N,Z,F,L,C} flag register.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    // Only N and Z participate in any condition.
    logic unused_flags;
    assign unused_flags = ^flags;

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_JUC:  taken = 1'b1;
            COND_BEQ:  taken = flags[FLAG_Z];
            COND_BNEQ: taken = ~flags[FLAG_Z];
            COND_BGT:  taken = flags[FLAG_N];
            COND_BLT:  taken = ~flags[FLAG_N] & ~flags[FLAG_Z];
            COND_BGE:  taken = flags[FLAG_N] | flags[FLAG_Z];
            COND_BLE:  taken = ~flags[FLAG_N];
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control FSM: owns PC and IR, sequences fetch/latch/execute/memory and
// gates the register-file, flag and data-memory strobes.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [17:0]       imem_rdata,
    output logic [17:0]       ir,
    input  logic [15:0]       jump_target,
    input  logic [4:0]        flags,
    output logic              reg_we,
    output logic              flag_we,
    output logic              dmem_we,
    output logic              dmem_re,
    output logic              sel_mem,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        state
);

    state_t            cur_state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc_next;
    iclass_t           iclass;
    logic              cond_taken;
    logic              take_jump;

    // Bits of the target above the PC width are dropped.
    logic unused_jt;
    assign unused_jt = ^jump_target;

    assign imem_addr = pc;
    assign state     = cur_state;
    assign iclass    = classify(ir);
    assign take_jump = (iclass == C_JCOND) && cond_taken;

    branch_cond_eval u_cond (
        .cond  (ir[3:0]),
        .flags (flags),
        .taken (cond_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
        end else begin
            cur_state <= next_state;
            pc        <= pc_next;
            if (cur_state == S_LATCH) begin
                ir <= imem_rdata;
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        pc_next    = pc;
        reg_we     = 1'b0;
        flag_we    = 1'b0;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        sel_mem    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                if (enable) begin
                    next_state = S_LATCH;
                end
            end
            S_LATCH: next_state = S_EXEC;
            S_EXEC: begin
                next_state = S_FETCH;
                pc_next    = take_jump ? jump_target[ADDR_W-1:0] : pc + ADDR_W'(1);
                case (iclass)
                    C_LI, C_OTHER: reg_we = 1'b1;
                    C_ARITH: begin
                        reg_we  = 1'b1;
                        flag_we = 1'b1;
                    end
                    C_CMP:  flag_we = 1'b1;
                    C_STOR: dmem_we = 1'b1;
                    C_LOAD: begin
                        dmem_re    = 1'b1;
                        next_state = S_MEM;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_re    = 1'b1;
                sel_mem    = 1'b1;
                reg_we     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
        // A reset edge discards the instruction, so nothing may commit this cycle.
        if (reset) begin
            reg_we  = 1'b0;
            flag_we = 1'b0;
            dmem_we = 1'b0;
            dmem_re = 1'b0;
            sel_mem = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model predicts per-instruction
// strobe timing, latency and next PC; a monitor checks each retired instruction.
module tb_cpu_sequencer;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [ADDR_W-1:0] imem_addr;
    logic [17:0]       imem_rdata;
    logic [17:0]       ir;
    logic [15:0]       jump_target;
    logic [4:0]        flags;
    logic              reg_we, flag_we, dmem_we, dmem_re, sel_mem;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        state;

    cpu_sequencer #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .jump_target (jump_target),
        .flags       (flags),
        .reg_we      (reg_we),
        .flag_we     (flag_we),
        .dmem_we     (dmem_we),
        .dmem_re     (dmem_re),
        .sel_mem     (sel_mem),
        .pc          (pc),
        .state       (state)
    );

    always #5 clk = ~clk;

    logic [17:0] imem [0:1023];
    always @(posedge clk) imem_rdata <= imem[imem_addr];

    // Strobe masks: bit k set means the strobe was high in cycle k of the instruction
    // (0 fetch, 1 latch, 2 execute, 3 memory).
    typedef struct {
        logic [17:0] ir;
        logic [9:0]  npc;
        int          lat;
        logic [3:0]  mReg;
        logic [3:0]  mFlag;
        logic [3:0]  mDwe;
        logic [3:0]  mDre;
        logic [3:0]  mSel;
    } expT;

    expT         sbq[$];
    int          compared = 0;
    int          mismatched = 0;
    int          retired = 0;
    bit          monOn = 0;
    logic [9:0]  mpc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic expT modelInstr(input logic [17:0] instr, input logic [4:0] f,
                                       input logic [15:0] jt, input logic [9:0] curPc);
        expT        e;
        logic [3:0] op;
        logic [3:0] ext;
        bit         n, z, tk;
        e.ir = instr; e.npc = curPc + 10'd1; e.lat = 3;
        e.mReg = 0; e.mFlag = 0; e.mDwe = 0; e.mDre = 0; e.mSel = 0;
        op = instr[15:12]; ext = instr[7:4];
        n = f[4]; z = f[3]; tk = 0;
        if (instr[17:16] == 2'b11) begin
            e.mReg = 4'b0100;
        end else if (instr[17:16] != 2'b00) begin
            e.lat = 3;
        end else if (op == 4'b0100) begin
            if (ext == 4'b0000) begin
                e.lat = 4; e.mDre = 4'b1100; e.mReg = 4'b1000; e.mSel = 4'b1000;
            end else if (ext == 4'b0100) begin
                e.mDwe = 4'b0100;
            end else if (ext == 4'b1100) begin
                case (instr[3:0])
                    4'b1110: tk = 1;
                    4'b0000: tk = z;
                    4'b0001: tk = !z;
                    4'b0110: tk = n;
                    4'b0111: tk = !n && !z;
                    4'b1101: tk = n || z;
                    4'b1100: tk = !n;
                    default: tk = 0;
                endcase
                if (tk) e.npc = jt[9:0];
            end
        end else if ((op == 4'b0000 && ext == 4'b1011) || op == 4'b1011 || op == 4'b1110) begin
            e.mFlag = 4'b0100;
        end else if ((op == 4'b0000 && ext inside {4'b0101, 4'b0110, 4'b0111, 4'b0100, 4'b1001})
                     || op inside {4'b0101, 4'b0110, 4'b0111, 4'b1010, 4'b1001}) begin
            e.mReg = 4'b0100; e.mFlag = 4'b0100;
        end else begin
            e.mReg = 4'b0100;
        end
        return e;
    endfunction

    // Monitor: accumulates strobes per instruction and retires on the return to fetch.
    int         idx = 0;
    bit         busy = 0;
    logic [3:0] aReg = 0, aFlag = 0, aDwe = 0, aDre = 0, aSel = 0;
    always @(negedge clk) begin
        expT e;
        int  b;
        if (reset || !monOn) begin
            busy = 0; idx = 0;
            aReg = 0; aFlag = 0; aDwe = 0; aDre = 0; aSel = 0;
        end else begin
            if (state == 2'b00 && busy) begin
                if (sbq.size() == 0) begin
                    checkOutput("sb-empty", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("ir", 32'(ir), 32'(e.ir));
                    checkOutput("next-pc", 32'(pc), 32'(e.npc));
                    checkOutput("latency", 32'(idx + 1), 32'(e.lat));
                    checkOutput("reg_we-cycles", 32'(aReg), 32'(e.mReg));
                    checkOutput("flag_we-cycles", 32'(aFlag), 32'(e.mFlag));
                    checkOutput("dmem_we-cycles", 32'(aDwe), 32'(e.mDwe));
                    checkOutput("dmem_re-cycles", 32'(aDre), 32'(e.mDre));
                    checkOutput("sel_mem-cycles", 32'(aSel), 32'(e.mSel));
                end
                busy = 0;
                aReg = 0; aFlag = 0; aDwe = 0; aDre = 0; aSel = 0;
                retired++;
            end
            if (state == 2'b00) idx = 0;
            else if (state == 2'b01) begin idx = 1; busy = 1; end
            else idx = idx + 1;
            b = (idx > 3) ? 3 : idx;
            aReg[b]  = aReg[b]  | reg_we;
            aFlag[b] = aFlag[b] | flag_we;
            aDwe[b]  = aDwe[b]  | dmem_we;
            aDre[b]  = aDre[b]  | dmem_re;
            aSel[b]  = aSel[b]  | sel_mem;
        end
    end

    task automatic waitCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [17:0] instr, input logic [4:0] f,
                                 input logic [15:0] jt, input int idle, output bit hung);
        expT e;
        int  start;
        imem[mpc]   = instr;
        flags       = f;
        jump_target = jt;
        e = modelInstr(instr, f, jt, mpc);
        sbq.push_back(e);
        mpc = e.npc;
        if (idle > 0) begin
            enable = 1'b0;
            repeat (idle) waitCycle();
        end
        enable = 1'b1;
        start  = retired;
        for (int k = 0; k < 20 && retired == start; k++) waitCycle();
        hung = (retired == start);
        if (hung) checkOutput("retire-timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit          hung;
        logic [17:0] instr;
        int          sel;

        for (int i = 0; i < 1024; i++) imem[i] = 18'h1_0000;
        reset = 1'b1; enable = 1'b0; flags = '0; jump_target = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset-state", 32'(state), 32'd0);
        checkOutput("reset-pc", 32'(pc), 32'd0);
        checkOutput("reset-ir", 32'(ir), 32'd0);
        checkOutput("reset-strobes", 32'({reg_we, flag_we, dmem_we, dmem_re, sel_mem}), 32'd0);
        waitCycle();
        reset = 1'b0;
        mpc   = '0;
        monOn = 1;

        applyStimulus(18'h0_5105, 5'b00000, 16'h0000, 0, hung);
        applyStimulus(18'h0_4203, 5'b10101, 16'h0000, 0, hung);
        applyStimulus(18'h1_0000, 5'b00000, 16'h0000, 0, hung);
        applyStimulus(18'h0_4243, 5'b00000, 16'h0000, 0, hung);
        applyStimulus(18'h0_44C0, 5'b01000, 16'h0123, 1, hung);
        applyStimulus(18'h0_44C0, 5'b10111, 16'h0123, 0, hung);
        applyStimulus(18'h0_44CE, 5'b00000, 16'hF3FF, 0, hung);
        applyStimulus(18'h1_0000, 5'b11111, 16'h0000, 0, hung);
        applyStimulus(18'h0_44C2, 5'b11111, 16'h0055, 2, hung);
        applyStimulus(18'h0_0B12, 5'b00000, 16'h0000, 0, hung);

        for (int i = 0; i < 80 && !hung; i++) begin
            instr = 18'($urandom);
            case ($urandom_range(0, 4))
                1: begin
                    instr[17:12] = 6'b000100;
                    sel = $urandom_range(0, 3);
                    case (sel)
                        0: instr[7:4] = 4'b0000;
                        1: instr[7:4] = 4'b0100;
                        2: instr[7:4] = 4'b1100;
                        default: ;
                    endcase
                end
                2: begin
                    instr[17:12] = 6'b000100;
                    instr[7:4]   = 4'b1100;
                end
                3: instr[17:12] = 6'b000000;
                4: instr[17:16] = 2'b00;
                default: ;
            endcase
            applyStimulus(instr, 5'($urandom), 16'($urandom), $urandom_range(0, 2), hung);
        end
        checkOutput("sb-drain", 32'(sbq.size()), 32'd0);

        // Reset in the memory cycle of a LOAD must suppress its writeback.
        monOn = 0;
        imem[mpc] = 18'h0_4203;
        enable = 1'b1;
        for (int k = 0; k < 10 && state != 2'b11; k++) waitCycle();
        checkOutput("reach-mem", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("reset-mem-reg_we", 32'(reg_we), 32'd0);
        checkOutput("reset-mem-dmem_re", 32'(dmem_re), 32'd0);
        checkOutput("reset-mem-sel_mem", 32'(sel_mem), 32'd0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("post-reset-state", 32'(state), 32'd0);
        checkOutput("post-reset-pc", 32'(pc), 32'd0);
        checkOutput("post-reset-ir", 32'(ir), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("idle-state", 32'(state), 32'd0);
            checkOutput("idle-pc", 32'(pc), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
